cmp_sequencer: RTL

Command-side initiator for the ALU compare unit. It accepts one operand pair plus a mask of compare functions over a valid/ready handshake. It issues each selected function (EQ, GT, LT) to the compare unit one per cycle and decodes the registered compare codes the unit returns. It then presents a 3-bit result vector and an error flag over a second valid/ready handshake. It sits between the ALU control path and the compare unit, driving that unit's A/B/ALU_FUNC/CMP_Enable inputs and consuming its CMP_OUT/CMP_Flag outputs.

---
 rtl/cmp_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cmp_sequencer.sv
// cmp_sequencer: issues the masked EQ/GT/LT functions to the ALU compare unit
// one per cycle, decodes the returned codes and hands back a result vector.
module cmp_sequencer #(
    parameter int IN_DATA_WIDTH  = 16,
    parameter int OUT_DATA_WIDTH = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CMD_VALID,
    output logic                      CMD_READY,
    input  logic [IN_DATA_WIDTH-1:0]  CMD_A,
    input  logic [IN_DATA_WIDTH-1:0]  CMD_B,
    input  logic [2:0]                CMD_MASK,
    output logic [IN_DATA_WIDTH-1:0]  A,
    output logic [IN_DATA_WIDTH-1:0]  B,
    output logic [1:0]                ALU_FUNC,
    output logic                      CMP_Enable,
    input  logic [OUT_DATA_WIDTH-1:0] CMP_OUT,
    input  logic                      CMP_Flag,
    output logic                      RES_VALID,
    input  logic                      RES_READY,
    output logic [2:0]                RES_VEC,
    output logic                      RES_ERR
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ISSUE = 2'b01;
    localparam logic [1:0] S_DRAIN = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    localparam logic [1:0] F_IDLE = 2'b00;
    localparam logic [1:0] F_EQ   = 2'b01;
    localparam logic [1:0] F_GT   = 2'b10;
    localparam logic [1:0] F_LT   = 2'b11;

    logic [1:0] r_state;
    logic [2:0] r_pending;
    logic [2:0] r_orig_mask;
    logic       r_cap_valid;
    logic [1:0] r_cap_func;

    logic       w_accept;
    logic [2:0] w_issue_src;
    logic [1:0] w_next_func;
    logic [2:0] w_next_pending;
    logic       w_hit;
    logic [2:0] w_vec_next;

    function automatic logic [1:0] lowest_func(input logic [2:0] m);
        logic [1:0] f;
        f = F_IDLE;
        if (m[0])      f = F_EQ;
        else if (m[1]) f = F_GT;
        else if (m[2]) f = F_LT;
        return f;
    endfunction

    assign CMD_READY = (r_state == S_IDLE) && !RST;
    assign RES_VALID = (r_state == S_DONE);
    assign w_accept  = CMD_VALID && CMD_READY;

    // Outputs are registered, so the function shown next cycle is chosen now:
    // from the incoming mask at acceptance, from the pending mask in ISSUE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        w_issue_src    = (r_state == S_IDLE) ? CMD_MASK : r_pending;
        w_next_func    = lowest_func(w_issue_src);
        w_next_pending = w_issue_src & (w_issue_src - 3'd1);
        w_hit          = (CMP_OUT == OUT_DATA_WIDTH'(r_cap_func));
        w_vec_next     = RES_VEC;
        if (r_cap_valid) begin
            case (r_cap_func)
                F_EQ:    w_vec_next[0] = w_hit;
                F_GT:    w_vec_next[1] = w_hit;
                F_LT:    w_vec_next[2] = w_hit;
                default: w_vec_next = RES_VEC;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_pending   <= 3'b000;
            r_orig_mask <= 3'b000;
            r_cap_valid <= 1'b0;
            r_cap_func  <= F_IDLE;
            A           <= '0;
            B           <= '0;
            ALU_FUNC    <= F_IDLE;
            CMP_Enable  <= 1'b0;
            RES_VEC     <= 3'b000;
            RES_ERR     <= 1'b0;
        end else begin
            // One-stage capture pipe: the code issued last cycle is checked now.
            r_cap_valid <= CMP_Enable;
            r_cap_func  <= ALU_FUNC;
            RES_VEC     <= w_vec_next;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        A           <= CMD_A;
                        B           <= CMD_B;
                        r_orig_mask <= CMD_MASK;
                        RES_VEC     <= 3'b000;
                        RES_ERR     <= 1'b0;
                        r_pending   <= w_next_pending;
                        ALU_FUNC    <= w_next_func;
                        CMP_Enable  <= (CMD_MASK != 3'b000);
                        r_state     <= (CMD_MASK == 3'b000) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!CMP_Flag) RES_ERR <= 1'b1;
                    r_pending  <= w_next_pending;
                    ALU_FUNC   <= w_next_func;
                    CMP_Enable <= (r_pending != 3'b000);
                    if (r_pending == 3'b000) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Full mask: exactly one of EQ/GT/LT must hold.
                    if (r_orig_mask == 3'b111 && $countones(w_vec_next) != 1)
                        RES_ERR <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (RES_READY) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
